// File: rtl/serial_digit_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_digit_adder_pkg
// Purpose  : State encoding and counter-width helper for the digit-serial adder
// Revision : 1.0
// ============================================================================
package serial_digit_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A single-digit configuration still needs a 1-bit index register.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_digit_adder_rca_digit.sv
`default_nettype none
// ============================================================================
// Module   : rca_digit
// Purpose  : Combinational DIGIT-bit ripple-carry adder; exposes carry into MSB
// Revision : 1.0
// ============================================================================
module rca_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [DIGIT:0] w_c;

    always_comb begin
        w_c    = '0;
        sum    = '0;
        w_c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]   = a[i] ^ b[i] ^ w_c[i];
            w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
        cout     = w_c[DIGIT];
        c_msb_in = w_c[DIGIT-1];
    end

endmodule
`default_nettype wire

// File: rtl/serial_digit_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_digit_adder
// Purpose  : Adds/subtracts two WIDTH-bit operands DIGIT bits per clock
// Revision : 1.0
// ============================================================================
module serial_digit_adder
    import serial_digit_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int               C_NDIG = WIDTH / DIGIT;
    localparam int               C_CW   = cnt_width(C_NDIG);
    localparam logic [C_CW-1:0]  C_LAST = C_CW'(C_NDIG - 1);

    generate
        if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_cfg_check
            $error("serial_digit_adder: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              sub_q, sub_d;
    logic              carry_q, carry_d;
    logic [C_CW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [DIGIT-1:0]  w_dig_a;
    logic [DIGIT-1:0]  w_dig_b;
    logic [DIGIT-1:0]  w_dig_sum;
    logic              w_dig_cout;
    logic              w_dig_cmsb;

    // Select the current digit; subtraction feeds the inverted B digit.
    always_comb begin
        w_dig_a = '0;
        w_dig_b = '0;
        for (int k = 0; k < C_NDIG; k++) begin
            if (idx_q == C_CW'(k)) begin
                w_dig_a = a_q[k*DIGIT +: DIGIT];
                w_dig_b = sub_q ? ~b_q[k*DIGIT +: DIGIT] : b_q[k*DIGIT +: DIGIT];
            end
        end
    end

    rca_digit #(
        .DIGIT (DIGIT)
    ) u_rca (
        .a        (w_dig_a),
        .b        (w_dig_b),
        .cin      (carry_q),
        .sum      (w_dig_sum),
        .cout     (w_dig_cout),
        .c_msb_in (w_dig_cmsb)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    carry_d = sub ? ~cin : cin;
                    sum_d   = '0;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                for (int k = 0; k < C_NDIG; k++) begin
                    if (idx_q == C_CW'(k)) begin
                        sum_d[k*DIGIT +: DIGIT] = w_dig_sum;
                    end
                end
                carry_d = w_dig_cout;
                if (idx_q == C_LAST) begin
                    cout_d  = w_dig_cout;
                    ovf_d   = w_dig_cout ^ w_dig_cmsb;
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + C_CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_serial_digit_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_digit_adder
// Purpose  : Directed, self-checking bench for serial_digit_adder (16/4 and 8/8)
// Revision : 1.0
// ============================================================================
module tb_serial_digit_adder;

    localparam int W    = 16;
    localparam int D    = 4;
    localparam int NDIG = W / D;
    localparam int W2   = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          start = 1'b0, sub = 1'b0, cin = 1'b0;
    logic [W-1:0]  a = '0, b = '0;
    logic [W-1:0]  sum;
    logic          cout, ovf, busy, done;

    logic          start2 = 1'b0, sub2 = 1'b0, cin2 = 1'b0;
    logic [W2-1:0] a2 = '0, b2 = '0;
    logic [W2-1:0] sum2;
    logic          cout2, ovf2, busy2, done2;

    serial_digit_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy), .done(done)
    );

    serial_digit_adder #(.WIDTH(W2), .DIGIT(W2)) u_dut8 (
        .clk(clk), .rst(rst), .start(start2), .sub(sub2), .a(a2), .b(b2), .cin(cin2),
        .sum(sum2), .cout(cout2), .ovf(ovf2), .busy(busy2), .done(done2)
    );

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } res_t;

    int   n_cmp = 0;
    int   n_err = 0;
    res_t exp_q[$];
    res_t last;
    bit   last_valid = 1'b0;

    task automatic chk(input string name, input longint act, input longint expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
        end
    endtask

    // Arithmetic reference: plain integer add/subtract plus signed range test.
    task automatic model(input int w, input longint ua, input longint ub, input bit ci,
                         input bit sb, output longint s, output bit c, output bit v);
        longint m, h, sa, sbv, u, si;
        m   = longint'(1) << w;
        h   = m >> 1;
        sa  = (ua >= h) ? ua - m : ua;
        sbv = (ub >= h) ? ub - m : ub;
        if (!sb) begin
            u  = ua + ub + longint'(ci);
            si = sa + sbv + longint'(ci);
            c  = (u >= m);
        end else begin
            u  = ua - ub - longint'(ci);
            si = sa - sbv - longint'(ci);
            c  = (u >= 0);
        end
        s = ((u % m) + m) % m;
        v = (si >= h) || (si < -h);
    endtask

    always @(negedge clk) begin : p_compare
        res_t e;
        if (!rst) begin
            chk("busy_done_exclusive", longint'(busy & done), 0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("done_without_start", longint'(done), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("model_sum",  longint'(sum),  longint'(e.s));
                    chk("model_cout", longint'(cout), longint'(e.c));
                    chk("model_ovf",  longint'(ovf),  longint'(e.v));
                    last       = e;
                    last_valid = 1'b1;
                end
            end else if (!busy && last_valid) begin
                chk("hold_sum",  longint'(sum),  longint'(last.s));
                chk("hold_cout", longint'(cout), longint'(last.c));
                chk("hold_ovf",  longint'(ovf),  longint'(last.v));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input bit tci, input bit tsb);
        res_t   e;
        longint s;
        bit     c, v;
        a = ta; b = tb; cin = tci; sub = tsb; start = 1'b1;
        model(W, longint'(ta), longint'(tb), tci, tsb, s, c, v);
        e.s = s[W-1:0];
        e.c = c;
        e.v = v;
        exp_q.push_back(e);
        tick();
        start = 1'b0;
    endtask

    task automatic finish_op(input string name, input logic [W-1:0] xs, input bit xc,
                             input bit xv, input int edges0, input int busy0);
        int edges, nbusy;
        edges = edges0;
        nbusy = busy0;
        while (!done && edges < 40) begin
            if (busy) nbusy++;
            tick();
            edges++;
        end
        if (!done) begin
            chk({name, "_timeout"}, longint'(done), 1);
        end else begin
            chk({name, "_latency"}, edges, NDIG + 1);
            chk({name, "_busy_cycles"}, nbusy, NDIG);
            chk({name, "_sum"},  longint'(sum),  longint'(xs));
            chk({name, "_cout"}, longint'(cout), longint'(xc));
            chk({name, "_ovf"},  longint'(ovf),  longint'(xv));
        end
    endtask

    task automatic run8(input string name, input logic [W2-1:0] ta, input logic [W2-1:0] tb,
                        input bit tci, input bit tsb, input logic [W2-1:0] xs,
                        input bit xc, input bit xv);
        int     edges;
        longint s;
        bit     c, v;
        model(W2, longint'(ta), longint'(tb), tci, tsb, s, c, v);
        a2 = ta; b2 = tb; cin2 = tci; sub2 = tsb; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        edges  = 1;
        while (!done2 && edges < 20) begin
            tick();
            edges++;
        end
        chk({name, "_done"},    longint'(done2), 1);
        chk({name, "_latency"}, edges, 2);
        chk({name, "_sum"},  longint'(sum2),  longint'(xs));
        chk({name, "_cout"}, longint'(cout2), longint'(xc));
        chk({name, "_ovf"},  longint'(ovf2),  longint'(xv));
        chk({name, "_model_sum"},  longint'(sum2),  s);
        chk({name, "_model_cout"}, longint'(cout2), longint'(c));
        chk({name, "_model_ovf"},  longint'(ovf2),  longint'(v));
        tick();
    endtask

    initial begin : p_stim
        bit seen_done;

        // Reset held two cycles with start asserted: nothing may be accepted.
        rst = 1'b1; start = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b1;
        tick();
        tick();
        chk("rst_sum",  longint'(sum),  0);
        chk("rst_cout", longint'(cout), 0);
        chk("rst_ovf",  longint'(ovf),  0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_sum8", longint'(sum2), 0);
        rst = 1'b0; start = 1'b0;
        last = '0; last_valid = 1'b1;
        tick();
        chk("start_under_rst_ignored", longint'(busy), 0);
        tick();

        launch(16'h1234, 16'h0FCD, 1'b0, 1'b0);
        finish_op("add", 16'h2201, 1'b0, 1'b0, 1, 0);
        tick();

        launch(16'hFFFF, 16'h0001, 1'b1, 1'b0);
        finish_op("wrap_cin", 16'h0001, 1'b1, 1'b0, 1, 0);
        tick();

        launch(16'h7FFF, 16'hFFFF, 1'b0, 1'b1);
        finish_op("sub_ovf", 16'h8000, 1'b0, 1'b1, 1, 0);
        tick();

        launch(16'h0005, 16'h0003, 1'b1, 1'b1);
        finish_op("sub_bin", 16'h0001, 1'b1, 1'b0, 1, 0);
        tick();

        // start pulsed mid-RUN with different operands and mode.
        launch(16'h00FF, 16'h0F01, 1'b0, 1'b0);
        tick();
        a = 16'hAAAA; b = 16'h5555; sub = 1'b1; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        finish_op("midrun_start", 16'h1000, 1'b0, 1'b0, 3, 2);

        // Back-to-back: new start issued in the DONE cycle.
        launch(16'h4000, 16'h4000, 1'b0, 1'b0);
        finish_op("b2b_first", 16'h8000, 1'b0, 1'b1, 1, 0);
        launch(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        finish_op("b2b_second", 16'hFFFE, 1'b1, 1'b0, 1, 0);
        tick();

        // Reset during the second RUN cycle aborts the operation.
        launch(16'h8000, 16'h8000, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        last = '0;
        chk("abort_busy", longint'(busy), 0);
        chk("abort_done", longint'(done), 0);
        chk("abort_sum",  longint'(sum),  0);
        chk("abort_cout", longint'(cout), 0);
        chk("abort_ovf",  longint'(ovf),  0);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen_done |= done;
        end
        chk("abort_no_done", longint'(seen_done), 0);

        launch(16'h0001, 16'h0001, 1'b0, 1'b0);
        finish_op("post_abort_add", 16'h0002, 1'b0, 1'b0, 1, 0);
        tick();
        chk("queue_drained", exp_q.size(), 0);

        run8("w8_add", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        run8("w8_sub", 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
